spi_peripheral: RTL and testbench
=================================

# spi_peripheral

SPI responder (mode 0, MSB first) that sits on the far side of the team's `spi_controller` link, e.g. in the FPGA-to-FPGA or test-loopback path. It oversamples the incoming SPI pins on the system clock, shifts a word in on `spi_din` while shifting a pre-loaded word out on `spi_dout`, and exchanges words with the fabric over the same `axiiv/axiid/axiov/axiod/axiready` stream signalling the controller uses.

## Interface
- `TRANSACTION_LENGTH_BITS`, default 8: bits per frame; also the width of `axiid` and `axiod`.
- `SYNC_STAGES`, default 2: flip-flop depth of each pin synchronizer. Must be at least 2.
- `IDLE_WORD`, default 0: word shifted out when no transmit word is buffered at frame start.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_cs_n`  in  1  chip select from the controller, active low.
- `spi_clk`  in  1  SPI clock from the controller, idle low.
- `spi_din`  in  1  controller-to-peripheral data (MOSI).
- `spi_dout`  out  1  peripheral-to-controller data (MISO); actively driven, no tristate.
- `axiiv`  in  1  transmit word valid.
- `axiid`  in  N  transmit word.
- `axiready`  out  1  transmit holding register empty.
- `axiov`  out  1  one-cycle pulse: received word valid.
- `axiod`  out  N  received word; held until the next `axiov`.
- `frame_error`  out  1  one-cycle pulse: `spi_cs_n` rose before N bits were received.
- `tx_underrun`  out  1  one-cycle pulse: a frame started with the holding register empty.

## Operation
- **Synchronizers.** `spi_cs_n`, `spi_clk` and `spi_din` each pass through `SYNC_STAGES` flops. Reset values: cs 1, clk 0, din 0. Edges are detected from the last stage against a one-cycle-delayed copy: `cs_fall`, `cs_rise`, `sck_rise`, `sck_fall`.
- **Transmit holding register (1 entry).** `axiiv && axiready` captures `axiid` and clears `axiready` on the next cycle. `axiiv` while `axiready` is 0 is ignored; the word is dropped and the holder is not overwritten.
- **`armed` flag.** Cleared by reset; set whenever the synchronized cs is high. A frame can start only while `armed` is set, so a reset released mid-frame never joins that frame.
- **State IDLE.**
  - Transition: on `cs_fall && armed`, go to SHIFT.
  - If the holder is full, load the shift-out register from it and free the holder; `axiready` is 1 on the next cycle.
  - Otherwise, load `IDLE_WORD` and pulse `tx_underrun`.
  - On entry to SHIFT, clear the bit counter.
  - If `axiiv` arrives in the same cycle as `cs_fall` with the holder empty, the word goes to the holder and is used for the next frame; this frame underruns.
- **State SHIFT.**
  - `spi_dout` is the MSB of the shift-out register.
  - On `sck_rise`: shift the synchronized din into the LSB of the shift-in register and increment the counter.
  - On `sck_fall`: shift the shift-out register left by 1, filling with 0.
  - When the counter reaches N (the cycle after the Nth `sck_rise`): `axiod` gets the shift-in word, pulse `axiov`, go to DESELECT.
  - On `cs_rise` before N bits: pulse `frame_error`, discard the partial word (no `axiov`), go to IDLE. `cs_rise` takes priority over a coincident `sck_fall` or `sck_rise`.
- **State DESELECT.** `spi_dout` is 0. Further SCLK edges are ignored. On `cs_rise`, go to IDLE.
- **Outside SHIFT,** `spi_dout` is 0.
- **Counter width.** `$clog2(N+1)` bits; it never wraps within a frame.
- **Illegal state encoding:** go to IDLE.

## Timing
- **Reset values:**
  - `spi_dout`, `axiov`, `axiod`, `frame_error`, `tx_underrun`: 0.
  - `axiready`: 1.
  - State: IDLE. Holder empty. `armed`: 0.
- **Pin-to-action latency:** `SYNC_STAGES` + 1 clk cycles from a pin edge to the register update, and one more cycle to `spi_dout`.
- **SPI clock constraint:** each SCLK half-period must be at least `SYNC_STAGES` + 3 clk cycles. This holds with the controller's default `CLOCK_DIVISION` of 100.
- **Dout validity:** `spi_dout` must be stable before the controller's next `spi_clk` rise. This follows from the constraint above.
- **First bit:** the controller asserts cs and drives its first bit on the same SCLK fall. The MSB of the peripheral's word is on `spi_dout` `SYNC_STAGES` + 2 cycles after the cs pin falls.
- **Word throughput:** `axiov` follows the Nth synchronized `sck_rise` by exactly 1 cycle. `axiready` re-asserts exactly 1 cycle after `cs_fall` consumes the holder.

## Test plan
- **Loopback:** connect to `spi_controller` (N=8, DIV=100). Preload `axiid`=0xA5, controller sends 0x3C. Required: peripheral `axiov` once with `axiod`=0x3C; controller `axiod`=0xA5; no `frame_error` or `tx_underrun`.
- **Underrun:** start a frame with no word loaded, `IDLE_WORD`=0. Required: `tx_underrun` pulses once, the controller receives 0x00, and `axiod` still captures the MOSI byte.
- **Back-to-back:** 3 frames with 0x01, 0x80 and 0xFF, reloading `axiid` after each `axiready` rise. Required: MISO words arrive in that order; 3 `axiov` pulses.
- **Aborted frame:** raise `spi_cs_n` after 5 SCLK rises. Required: `frame_error` pulses once, no `axiov`. The next full frame with 0x5A passes cleanly.
- **Reset mid-frame:** assert `rst_n` low after bit 3 and release it while cs is still low. Required: all outputs at reset values and no `axiov` for that frame. The next frame after cs goes high then low completes normally.
- **Holder full:** drive `axiiv` with 0x11 then 0x22 while `axiready` is 0. Required: 0x11 is transmitted and 0x22 is dropped.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples the SPI pins on clk, shifts a word in on spi_din while
// shifting a buffered word out on spi_dout, and exchanges words with the fabric as a stream.
module spi_peripheral #(
    parameter int unsigned TRANSACTION_LENGTH_BITS = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [TRANSACTION_LENGTH_BITS-1:0] IDLE_WORD = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               spi_cs_n,
    input  logic                               spi_clk,
    input  logic                               spi_din,
    output logic                               spi_dout,
    input  logic                               axiiv,
    input  logic [TRANSACTION_LENGTH_BITS-1:0] axiid,
    output logic                               axiready,
    output logic                               axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
    output logic                               frame_error,
    output logic                               tx_underrun
);
    localparam int unsigned N = TRANSACTION_LENGTH_BITS;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StDeselect = 2'd2} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d, fill_q, fill_d;
    logic cs_dly_q, cs_dly_d, sck_dly_q, sck_dly_d, armed_q, armed_d;
    logic cs_s, sck_s, din_s, cs_fall, cs_rise, sck_rise, sck_fall, start;

    logic [N-1:0]    hold_q, hold_d, sout_q, sout_d, sin_q, sin_d, axiod_q, axiod_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic hold_full_q, hold_full_d, dout_q, dout_d, axiov_q, axiov_d;
    logic ferr_q, ferr_d, under_q, under_d;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_dly_q & ~cs_s;
    assign cs_rise  = ~cs_dly_q & cs_s;
    assign sck_rise = ~sck_dly_q & sck_s;
    assign sck_fall = sck_dly_q & ~sck_s;
    assign start    = cs_fall & armed_q;

    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], spi_din};
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        cs_dly_d   = cs_s;
        sck_dly_d  = sck_s;
        // The chain's reset value is not a pin sample; only arm once a real high cs arrives.
        armed_d    = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            din_sync_q <= '0;
            fill_q     <= '0;
            cs_dly_q   <= 1'b1;
            sck_dly_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            din_sync_q <= din_sync_d;
            fill_q     <= fill_d;
            cs_dly_q   <= cs_dly_d;
            sck_dly_q  <= sck_dly_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StShift;
            end
            StShift: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (sck_rise && cnt_q == CntLast) begin
                    state_d = StDeselect;
                end
            end
            StDeselect: begin
                if (cs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sout_d      = sout_q;
        sin_d       = sin_q;
        cnt_d       = cnt_q;
        axiod_d     = axiod_q;
        axiov_d     = 1'b0;
        ferr_d      = 1'b0;
        under_d     = 1'b0;
        dout_d      = (state_q == StShift) ? sout_q[N-1] : 1'b0;

        if (axiiv && !hold_full_q) begin
            hold_d      = axiid;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sout_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        sout_d  = IDLE_WORD;
                        under_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (cs_rise) begin
                    ferr_d = 1'b1;
                end else begin
                    if (sck_rise) begin
                        sin_d = {sin_q[N-2:0], din_s};
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == CntLast) begin
                            axiod_d = sin_d;
                            axiov_d = 1'b1;
                        end
                    end
                    if (sck_fall) sout_d = {sout_q[N-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sout_q      <= '0;
            sin_q       <= '0;
            cnt_q       <= '0;
            axiod_q     <= '0;
            axiov_q     <= 1'b0;
            ferr_q      <= 1'b0;
            under_q     <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sout_q      <= sout_d;
            sin_q       <= sin_d;
            cnt_q       <= cnt_d;
            axiod_q     <= axiod_d;
            axiov_q     <= axiov_d;
            ferr_q      <= ferr_d;
            under_q     <= under_d;
            dout_q      <= dout_d;
        end
    end

    assign spi_dout    = dout_q;
    assign axiready    = ~hold_full_q;
    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign frame_error = ferr_q;
    assign tx_underrun = under_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a pin-level mode-0 controller drives frames while a small model of
// the one-entry transmit holder predicts MISO words, received words and status pulses.
module tb_spi_peripheral;
    localparam int N = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;
    localparam logic [7:0] IDLE = 8'h00;

    logic clk = 1'b0, rst_n = 1'b0;
    logic spi_cs_n = 1'b1, spi_clk = 1'b0, spi_din = 1'b0, axiiv = 1'b0;
    logic [7:0] axiid = '0;
    logic spi_dout, axiready, axiov, frame_error, tx_underrun;
    logic [7:0] axiod;

    spi_peripheral #(
        .TRANSACTION_LENGTH_BITS(N),
        .SYNC_STAGES(SYNC),
        .IDLE_WORD(IDLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_din(spi_din),
        .spi_dout(spi_dout), .axiiv(axiiv), .axiid(axiid), .axiready(axiready), .axiov(axiov),
        .axiod(axiod), .frame_error(frame_error), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int ov_cnt = 0, fe_cnt = 0, un_cnt = 0;
    always @(negedge clk) begin
        if (axiov) ov_cnt <= ov_cnt + 1;
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (tx_underrun) un_cnt <= un_cnt + 1;
    end

    // Reference model: one-entry holder plus the last completed received word.
    logic model_full = 1'b0;
    logic [7:0] model_word = '0, model_od = '0;

    typedef struct {
        logic [7:0]  miso;
        int          ov, fe, un;
        logic [7:0]  od;
        logic        dout_a, dout_b, rdy_a, rdy_b, ov_a, ov_b;
        logic [12:0] rst_vals;
    } obs_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(output logic [7:0] exp_miso, output int exp_un);
        exp_miso   = model_full ? model_word : IDLE;
        exp_un     = model_full ? 0 : 1;
        model_full = 1'b0;
    endtask

    task automatic load(input logic [7:0] w);
        int n = 0;
        while (!axiready && n < 50) begin
            tick(1);
            n++;
        end
        vecs++;
        if (n >= 50) begin
            errs++;
            $display("FAIL load_timeout: axiready still %b, required 1", axiready);
        end
        axiiv = 1'b1;
        axiid = w;
        tick(1);
        axiiv = 1'b0;
        if (!model_full) begin
            model_full = 1'b1;
            model_word = w;
        end
    endtask

    // Mode-0 frame: first bit driven with cs, MISO sampled just before each rising SCLK.
    task automatic xfer(input logic [7:0] mosi, input int nbits, input int rst_after,
                        output obs_t o);
        int ov0, fe0, un0;
        logic [7:0] sh;
        ov0 = ov_cnt; fe0 = fe_cnt; un0 = un_cnt;
        o.miso = '0; o.dout_a = 0; o.dout_b = 0; o.rdy_a = 0; o.rdy_b = 0;
        o.ov_a = 0; o.ov_b = 0; o.rst_vals = '0;
        sh = mosi;
        spi_cs_n = 1'b0;
        spi_din  = sh[7];
        for (int c = 1; c <= HALF; c++) begin
            tick(1);
            if (c == SYNC)     o.rdy_a = axiready;
            if (c == SYNC + 1) begin o.rdy_b = axiready; o.dout_a = spi_dout; end
            if (c == SYNC + 2) o.dout_b = spi_dout;
        end
        for (int i = 0; i < nbits; i++) begin
            o.miso  = {o.miso[6:0], spi_dout};
            spi_clk = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                tick(1);
                if (i == N - 1 && c == SYNC)     o.ov_a = axiov;
                if (i == N - 1 && c == SYNC + 1) o.ov_b = axiov;
            end
            spi_clk = 1'b0;
            sh      = sh << 1;
            spi_din = sh[7];
            tick(HALF);
            if (i + 1 == rst_after) begin
                rst_n = 1'b0;
                tick(2);
                o.rst_vals = {spi_dout, axiov, axiod, frame_error, tx_underrun, axiready};
                rst_n = 1'b1;
                tick(1);
            end
        end
        spi_cs_n = 1'b1;
        tick(2 * HALF + SYNC + 4);
        o.ov = ov_cnt - ov0; o.fe = fe_cnt - fe0; o.un = un_cnt - un0; o.od = axiod;
    endtask

    localparam logic [12:0] RstVals = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    task automatic test_reset();
        tick(3);
        vecs++;
        if ({spi_dout, axiov, axiod, frame_error, tx_underrun, axiready} !== RstVals) begin
            errs++;
            $display("FAIL reset_outputs: got %h required %h",
                     {spi_dout, axiov, axiod, frame_error, tx_underrun, axiready}, RstVals);
        end
        rst_n = 1'b1;
        tick(10);
        vecs++;
        if (axiready !== 1'b1) begin
            errs++; $display("FAIL reset_ready: got %b required 1", axiready);
        end
    endtask

    task automatic test_loopback();
        obs_t o; logic [7:0] em; int eu;
        load(8'hA5);
        vecs++;
        if (axiready !== 1'b0) begin errs++; $display("FAIL lb_ready_full: got %b want 0", axiready); end
        model_frame(em, eu);
        xfer(8'h3C, N, -1, o);
        model_od = 8'h3C;
        vecs += 9;
        if (o.miso !== em)   begin errs++; $display("FAIL lb_miso: got %h want %h", o.miso, em); end
        if (o.od !== 8'h3C)  begin errs++; $display("FAIL lb_axiod: got %h want 3c", o.od); end
        if (o.ov !== 1)      begin errs++; $display("FAIL lb_axiov: got %0d want 1", o.ov); end
        if (o.fe !== 0 || o.un !== eu) begin
            errs++; $display("FAIL lb_status: fe %0d un %0d want 0 %0d", o.fe, o.un, eu);
        end
        if (o.dout_a !== 1'b0) begin errs++; $display("FAIL lb_dout_early: got %b want 0", o.dout_a); end
        if (o.dout_b !== em[7]) begin errs++; $display("FAIL lb_first_bit: got %b want %b", o.dout_b, em[7]); end
        if (o.rdy_a !== 1'b0) begin errs++; $display("FAIL lb_ready_early: got %b want 0", o.rdy_a); end
        if (o.rdy_b !== 1'b1) begin errs++; $display("FAIL lb_ready_back: got %b want 1", o.rdy_b); end
        if ({o.ov_a, o.ov_b} !== 2'b01) begin
            errs++; $display("FAIL lb_axiov_latency: got %b want 01", {o.ov_a, o.ov_b});
        end
    endtask

    task automatic test_underrun();
        obs_t o; logic [7:0] em, mosi; int eu;
        mosi = 8'($urandom);
        model_frame(em, eu);
        xfer(mosi, N, -1, o);
        model_od = mosi;
        vecs += 3;
        if (o.miso !== em) begin errs++; $display("FAIL ur_miso: got %h want %h", o.miso, em); end
        if (o.un !== eu)   begin errs++; $display("FAIL ur_pulse: got %0d want %0d", o.un, eu); end
        if (o.od !== mosi || o.ov !== 1) begin
            errs++; $display("FAIL ur_axiod: got %h/%0d want %h/1", o.od, o.ov, mosi);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; logic [7:0] em, mosi; int eu, total;
        logic [7:0] words [3];
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        total = 0;
        for (int k = 0; k < 3; k++) begin
            mosi = 8'($urandom);
            load(words[k]);
            model_frame(em, eu);
            xfer(mosi, N, -1, o);
            model_od = mosi;
            total += o.ov;
            vecs += 2;
            if (o.miso !== em) begin errs++; $display("FAIL b2b_miso[%0d]: got %h want %h", k, o.miso, em); end
            if (o.od !== mosi) begin errs++; $display("FAIL b2b_axiod[%0d]: got %h want %h", k, o.od, mosi); end
        end
        vecs++;
        if (total !== 3) begin errs++; $display("FAIL b2b_axiov_count: got %0d want 3", total); end
    endtask

    task automatic test_abort();
        obs_t o; logic [7:0] em, em_part; int eu;
        load(8'($urandom));
        model_frame(em, eu);
        xfer(8'($urandom), 5, -1, o);
        em_part = em >> (N - 5);
        vecs += 3;
        if (o.fe !== 1 || o.ov !== 0) begin
            errs++; $display("FAIL abort_status: fe %0d ov %0d want 1 0", o.fe, o.ov);
        end
        if (o.miso !== em_part) begin errs++; $display("FAIL abort_miso: got %h want %h", o.miso, em_part); end
        if (o.od !== model_od) begin errs++; $display("FAIL abort_axiod_held: got %h want %h", o.od, model_od); end
        load(8'($urandom));
        model_frame(em, eu);
        xfer(8'h5A, N, -1, o);
        model_od = 8'h5A;
        vecs += 2;
        if (o.od !== 8'h5A || o.ov !== 1) begin
            errs++; $display("FAIL abort_next_frame: got %h/%0d want 5a/1", o.od, o.ov);
        end
        if (o.fe !== 0 || o.miso !== em) begin
            errs++; $display("FAIL abort_next_clean: fe %0d miso %h want 0 %h", o.fe, o.miso, em);
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o; logic [7:0] em, mosi; int eu;
        load(8'hC3);
        xfer(8'($urandom), N, 3, o);
        model_full = 1'b0;
        model_od   = 8'h00;
        vecs += 2;
        if (o.rst_vals !== RstVals) begin
            errs++; $display("FAIL rst_mid_outputs: got %h want %h", o.rst_vals, RstVals);
        end
        if (o.ov !== 0 || o.fe !== 0 || o.un !== 0) begin
            errs++; $display("FAIL rst_mid_no_frame: ov %0d fe %0d un %0d want 0 0 0", o.ov, o.fe, o.un);
        end
        mosi = 8'($urandom);
        load(8'h96);
        model_frame(em, eu);
        xfer(mosi, N, -1, o);
        model_od = mosi;
        vecs++;
        if (o.miso !== em || o.od !== mosi || o.ov !== 1) begin
            errs++; $display("FAIL rst_mid_next: miso %h od %h ov %0d want %h %h 1", o.miso, o.od, o.ov, em, mosi);
        end
    endtask

    task automatic test_holder_full();
        obs_t o; logic [7:0] em, mosi; int eu;
        axiiv = 1'b1; axiid = 8'h11;
        tick(1);
        axiid = 8'h22;
        tick(1);
        axiiv = 1'b0;
        if (!model_full) begin model_full = 1'b1; model_word = 8'h11; end
        vecs++;
        if (axiready !== 1'b0) begin errs++; $display("FAIL hf_ready: got %b want 0", axiready); end
        mosi = 8'($urandom);
        model_frame(em, eu);
        xfer(mosi, N, -1, o);
        model_od = mosi;
        vecs++;
        if (o.miso !== em) begin errs++; $display("FAIL hf_miso: got %h want %h", o.miso, em); end
    endtask

    task automatic test_random();
        obs_t o; logic [7:0] em, mosi, ep; int eu, nb;
        for (int k = 0; k < 10; k++) begin
            mosi = 8'($urandom);
            nb = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : N;
            if ($urandom % 2 == 0) load(8'($urandom));
            model_frame(em, eu);
            xfer(mosi, nb, -1, o);
            ep = em >> (N - nb);
            if (nb == N) model_od = mosi;
            vecs += 3;
            if (o.miso !== ep) begin errs++; $display("FAIL rnd_miso[%0d]: got %h want %h", k, o.miso, ep); end
            if (o.od !== model_od) begin errs++; $display("FAIL rnd_axiod[%0d]: got %h want %h", k, o.od, model_od); end
            if (o.ov !== (nb == N ? 1 : 0) || o.fe !== (nb == N ? 0 : 1) || o.un !== eu) begin
                errs++;
                $display("FAIL rnd_status[%0d]: ov %0d fe %0d un %0d nbits %0d want un %0d",
                         k, o.ov, o.fe, o.un, nb, eu);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_holder_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
